mul_approx_trunc_pipe: RTL and testbench
========================================

MUL_APPROX_TRUNC_PIPE -- requirements
Module: mul_approx_trunc_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, legal range 4..32.
REQ-002 Parameter CUT, default 24: truncation column; legal range 0..2*WIDTH-1.
REQ-003 Parameter STAGES, default 2: pipeline register count, legal range 1..4.
REQ-004 Port clk  in  1: single clock; all state on rising edge.
REQ-005 Port rst_n  in  1: asynchronous, active-low reset.
REQ-006 Port in_valid  in  1: A, B, mode are presented this cycle.
REQ-007 Port in_ready  out  1: block accepts the presented operands this cycle.
REQ-008 Port A  in  WIDTH: unsigned multiplicand.
REQ-009 Port B  in  WIDTH: unsigned multiplier.
REQ-010 Port mode  in  1: 0 = exact product, 1 = column-truncated approximate product.
REQ-011 Port out_valid  out  1: O holds a result.
REQ-012 Port out_ready  in  1: downstream takes O this cycle.
REQ-013 Port O  out  2*WIDTH: unsigned product.

Function
REQ-014 Exact mode SHALL produce O = A*B, full 2*WIDTH bits.
REQ-015 Approx mode SHALL produce O = sum of A[i]&B[j] << (i+j) over all i+j >= CUT; partial products with i+j < CUT are dropped and carries from them are not generated.
REQ-016 In approx mode, O[CUT-1:0] SHALL be zero.
REQ-017 With CUT = 0, approx mode SHALL equal exact mode.
REQ-018 Mode SHALL be captured with its operands and travel with them; a mode change between transactions SHALL NOT affect transactions already in flight.
REQ-019 A transfer in occurs on in_valid & in_ready; a transfer out occurs on out_valid & out_ready.
REQ-020 Latency SHALL be exactly STAGES cycles from an accepted input to the corresponding out_valid when there is no stall.
REQ-021 The pipeline SHALL stall as a whole when out_valid & !out_ready; in_ready = out_ready | !out_valid.
REQ-022 While stalled, O and out_valid SHALL hold stable and no internal stage SHALL advance.
REQ-023 Accept rate is one transaction per cycle; results leave in acceptance order; no transaction is dropped or duplicated.
REQ-024 Bubbles (in_valid low) SHALL propagate as invalid stages; out_valid is low for them.
REQ-025 Simultaneous transfer in and transfer out in the same cycle SHALL both complete.
REQ-026 Operands of all-ones SHALL not overflow: O width 2*WIDTH always suffices.

Reset
REQ-027 On rst_n low: all stage valid bits, out_valid and O SHALL clear to 0 immediately, independent of clk.
REQ-028 in_ready SHALL be 1 while in reset and on the first cycle after release.
REQ-029 Reset during operation SHALL discard all in-flight transactions; none appear after release.

Structure
REQ-030 Shared package mul_approx_pkg SHALL hold the mode encoding constants (MODE_EXACT = 0, MODE_APPROX = 1) and the default WIDTH, CUT and STAGES values.
REQ-031 Partial-product generation and reduction SHALL be one combinational sub-module, mul_trunc_core (WIDTH, CUT, mode -> product).
REQ-032 The top level SHALL contain only the valid/stall pipeline around mul_trunc_core; retiming of the core into stages is permitted if latency is unchanged.

Verification (WIDTH=16, CUT=24, STAGES=2)
REQ-033 A=0x0800, B=0x1000: mode 0 -> O=0x00800000; mode 1 -> O=0x00000000, two cycles after accept.
REQ-034 A=0x1000, B=0x1000, mode 1 -> O=0x01000000, because column 24 is kept.
REQ-035 A=0x00FF, B=0x00FF: mode 0 -> O=0x0000FE01; mode 1 -> O=0x00000000.
REQ-036 Back-to-back 8 transactions with alternating mode and out_ready held low for cycles 3-5 -> in_ready low during the stall, O stable, all 8 results in order with correct per-transaction mode.
REQ-037 rst_n pulsed low with 2 transactions in flight -> out_valid=0 and O=0 immediately; no result emitted after release; in_ready=1.
REQ-038 Random operands, both modes, 10k transactions, random out_ready -> O matches the REQ-014/015 reference model; approx error never exceeds the dropped-column bound of sum over i+j<CUT of 2^(i+j).

Source files
------------

// File: rtl/mul_approx_pkg.sv
// Shared constants for the approximate truncated multiplier: mode encoding
// and default geometry.
package mul_approx_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_CUT    = 24;
    localparam int DEFAULT_STAGES = 2;

endpackage

// File: rtl/mul_trunc_core.sv
// Combinational partial-product multiplier. In approx mode every partial-product
// bit landing in a column below CUT is removed before reduction, so no carry is
// ever generated from those columns.
module mul_trunc_core
    import mul_approx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CUT   = DEFAULT_CUT
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               mode,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] KEEP_MASK = {PW{1'b1}} << CUT;

    logic [PW-1:0] col_mask;
    logic [PW-1:0] row [WIDTH];

    assign col_mask = (mode == MODE_APPROX) ? KEEP_MASK : {PW{1'b1}};

    // Row i holds A[i]&B[j] at column i+j; masking the shifted row drops
    // exactly the partial-product bits whose column is below CUT.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
            assign row[gi] = ({{WIDTH{1'b0}}, b & {WIDTH{a[gi]}}} << gi) & col_mask;
        end
    endgenerate

    always_comb begin
        product = '0;
        for (int i = 0; i < WIDTH; i++) begin
            product = product + row[i];
        end
    end

endmodule

// File: rtl/mul_approx_trunc_pipe.sv
// Valid/ready pipeline of STAGES registers around mul_trunc_core. The whole
// pipeline advances together and freezes while the output is held by downstream.
module mul_approx_trunc_pipe
    import mul_approx_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int CUT    = DEFAULT_CUT,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] O
);

    localparam int PW = 2 * WIDTH;

    logic              advance;
    logic [PW-1:0]     core_product;
    logic [STAGES-1:0] stage_valid_reg;
    logic [STAGES-1:0] stage_valid_next;
    logic [PW-1:0]     stage_data_reg  [STAGES];
    logic [PW-1:0]     stage_data_next [STAGES];

    // Mode is consumed by the core at acceptance, so it travels baked into the data.
    mul_trunc_core #(
        .WIDTH (WIDTH),
        .CUT   (CUT)
    ) u_core (
        .a       (A),
        .b       (B),
        .mode    (mode),
        .product (core_product)
    );

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_valid_next[gi] = in_valid;
                assign stage_data_next[gi]  = core_product;
            end else begin : g_body
                assign stage_valid_next[gi] = stage_valid_reg[gi-1];
                assign stage_data_next[gi]  = stage_data_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_reg <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stage_data_reg[s] <= '0;
            end
        end else if (advance) begin
            stage_valid_reg <= stage_valid_next;
            for (int s = 0; s < STAGES; s++) begin
                stage_data_reg[s] <= stage_data_next[s];
            end
        end
    end

    assign out_valid = stage_valid_reg[STAGES-1];
    assign O         = stage_data_reg[STAGES-1];

endmodule

// File: tb/tb_mul_approx_trunc_pipe.sv
// Scoreboard bench for mul_approx_trunc_pipe: directed corner cases, a scheduled
// stall, a mid-flight reset and a long randomized run with random backpressure.
module tb_mul_approx_trunc_pipe;
    import mul_approx_pkg::*;

    localparam int W   = 16;
    localparam int CUT = 24;
    localparam int ST  = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           mode = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] O;

    typedef struct {
        logic [2*W-1:0] o;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           m;
        int             cyc;
        bit             lat;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 3;   // 0: always ready, 1: scheduled stall, 2: random, 3: never ready
    int sched = 0;
    int txn_id = 0;
    bit verbose = 1'b1;
    longint unsigned drop_bound = 0;

    mul_approx_trunc_pipe #(
        .WIDTH  (W),
        .CUT    (CUT),
        .STAGES (ST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .O         (O)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact is plain multiplication; approx sums the kept partial-product bits.
    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                                   input logic m);
        longint unsigned acc;
        acc = 0;
        if (m == MODE_EXACT) begin
            acc = a;
            acc = acc * b;
        end else begin
            for (int i = 0; i < W; i++)
                for (int j = 0; j < W; j++)
                    if (a[i] && b[j] && (i + j >= CUT)) acc += 64'd1 << (i + j);
        end
        return acc[2*W-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input bit use_c, input logic [2*W-1:0] c);
        exp_t e;
        int waitc;
        waitc = 0;
        @(negedge clk);
        A = a; B = b; mode = m; in_valid = 1'b1;
        #1;
        while (!in_ready && waitc < 1000) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        e.o   = use_c ? c : ref_product(a, b, m);
        e.a   = a;
        e.b   = b;
        e.m   = m;
        e.cyc = cyc;
        e.lat = (ready_mode == 0);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            A = W'($urandom);
            B = W'($urandom);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            in_valid = 1'b0;
            #3;
            n++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Downstream readiness driver.
    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = !(sched >= 3 && sched <= 5);
                    sched++;
                end
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each transfer out and checks stall behaviour.
    initial begin
        exp_t e;
        bit prev_stall;
        logic [2*W-1:0] prev_o;
        logic [63:0] ex;
        prev_stall = 1'b0;
        prev_o = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_O", 64'(O), 64'(prev_o));
            end
            if (out_valid && !out_ready)
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    txn_id++;
                    chk($sformatf("O_A%h_B%h_m%0d", e.a, e.b, e.m), 64'(O), 64'(e.o));
                    if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(ST));
                    if (e.m == MODE_APPROX) begin
                        ex = 64'(e.a) * 64'(e.b);
                        checks++;
                        if (!(64'(O) <= ex && ex - 64'(O) <= drop_bound)) begin
                            failures++;
                            $display("FAIL approx_bound: got 0x%0h exact 0x%0h bound 0x%0h",
                                     O, ex, drop_bound);
                        end
                    end
                    if (verbose)
                        $display("txn %0d A=%h B=%h mode=%0d O=%h", txn_id, e.a, e.b, e.m, O);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_o = O;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (i + j < CUT) drop_bound += 64'd1 << (i + j);

        // Reset state.
        ready_mode = 3;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_O", 64'(O), 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        #4 rst_n = 1'b1;
        ready_mode = 0;
        @(negedge clk);
        #1;
        chk("in_ready_after_release", {63'd0, in_ready}, 64'd1);

        // Directed corners.
        send(16'h0800, 16'h1000, MODE_EXACT,  1'b1, 32'h0080_0000);
        idle(1);
        send(16'h0800, 16'h1000, MODE_APPROX, 1'b1, 32'h0000_0000);
        send(16'h1000, 16'h1000, MODE_APPROX, 1'b1, 32'h0100_0000);
        send(16'h00FF, 16'h00FF, MODE_EXACT,  1'b1, 32'h0000_FE01);
        idle(2);
        send(16'h00FF, 16'h00FF, MODE_APPROX, 1'b1, 32'h0000_0000);
        send(16'hFFFF, 16'hFFFF, MODE_EXACT,  1'b1, 32'hFFFE_0001);
        send(16'hFFFF, 16'hFFFF, MODE_APPROX, 1'b0, '0);
        wait_drain();

        // Eight back-to-back with alternating mode and a scheduled stall.
        ready_mode = 1;
        sched = 0;
        for (int k = 0; k < 8; k++)
            send(W'($urandom), W'($urandom), (k % 2 == 1) ? MODE_APPROX : MODE_EXACT, 1'b0, '0);
        wait_drain();
        ready_mode = 0;

        // Reset with two transactions in flight.
        idle(2);
        ready_mode = 3;
        send(16'h1234, 16'h5678, MODE_EXACT,  1'b0, '0);
        send(16'hABCD, 16'hEF01, MODE_APPROX, 1'b0, '0);
        wc = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            wc++;
        end while (!out_valid && wc < 20);
        chk("inflight_out_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_reset_O", 64'(O), 64'd0);
        chk("async_reset_in_ready", {63'd0, in_ready}, 64'd1);
        sb.delete();
        @(negedge clk);
        #5 rst_n = 1'b1;
        ready_mode = 0;
        @(negedge clk);
        #1;
        chk("in_ready_first_cycle", {63'd0, in_ready}, 64'd1);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("no_output_after_reset", {63'd0, out_valid}, 64'd0);
        end

        // Long randomized run with random backpressure and bubbles.
        verbose = 1'b0;
        ready_mode = 2;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(W'($urandom), W'($urandom), $urandom_range(0, 1) == 1 ? MODE_APPROX : MODE_EXACT,
                 1'b0, '0);
        end
        ready_mode = 0;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
